mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/rv32i_types_pkg.sv | 36 +++
 rtl/load_extend.sv | 28 ++
 rtl/mem_access_unit.sv | 160 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types_pkg.sv
// Shared RV32I load/store types: load kinds, memory-unit FSM states, alignment rule.
// Imported by the memory access unit and its load extension datapath.
package rv32i_types_pkg;

    typedef enum logic [2:0] {
        LB  = 3'd0,
        LH  = 3'd1,
        LW  = 3'd2,
        LBU = 3'd3,
        LHU = 3'd4
    } load_t;

    typedef enum logic [1:0] {
        MEM_IDLE   = 2'd0,
        MEM_ACCESS = 2'd1,
        MEM_DONE   = 2'd2
    } mem_state_t;

    localparam int BUSY_CNT_W = 8;

    // Stores are legal only as a single byte, an aligned halfword or a full word.
    function automatic logic access_misaligned(input logic       is_store,
                                               input load_t      lt,
                                               input logic [1:0] off,
                                               input logic [3:0] be);
        if (is_store)
            return !(be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                4'b0011, 4'b1100, 4'b1111});
        case (lt)
            LH, LHU: return off[0];
            LW:      return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Load return path: shifts the bus word down by the byte offset and sign/zero-extends it.
// Latency: combinational. Backpressure: none.
// Flow control: none, pure function of its inputs.
module load_extend
    import rv32i_types_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  byte_offset,
    input  load_t       load_type,
    output logic [31:0] data
);

    logic [31:0] shifted;

    assign shifted = rdata >> {byte_offset, 3'b000};

    always_comb begin
        data = shifted;
        case (load_type)
            LB:      data = {{24{shifted[7]}}, shifted[7:0]};
            LH:      data = {{16{shifted[15]}}, shifted[15:0]};
            LBU:     data = {24'd0, shifted[7:0]};
            LHU:     data = {16'd0, shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access unit: turns a load/store request into one word-aligned bus access.
// Latency: 2 cycles request->mem_done plus one per bus_busy cycle; aborts after BUS_TIMEOUT busy cycles.
// Backpressure: mem_stall holds the pipeline while a request is pending; MEM_MISALIGN_TRAP_EN adds the misalignment trap.
module mem_access_unit
    import rv32i_types_pkg::*;
#(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        dren,
    input  logic        dwen,
    input  logic [3:0]  byte_en,
    input  load_t       load_type,
    input  logic [1:0]  byte_offset,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic [31:0] bus_addr,
    output logic        bus_ren,
    output logic        bus_wen,
    output logic [3:0]  bus_byte_en,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_busy,
    output logic [31:0] load_data,
    output logic        mem_stall,
    output logic        mem_done,
    output logic        bus_error,
    output logic        misaligned
);

    mem_state_t            state_q, state_d;
    logic [31:2]           addr_q;
    logic [3:0]            be_q;
    load_t                 lt_q;
    logic [1:0]            off_q;
    logic [31:0]           wdata_q;
    logic                  store_q;
    logic [BUSY_CNT_W-1:0] cnt_q;
    logic                  err_q;
    logic [31:0]           load_data_q;
    logic [31:0]           ext_data;
    logic                  req;
    logic                  mis_now;
    logic                  timeout_hit;
    logic                  unused_addr_lsb;

    // The low address bits arrive separately as byte_offset.
    assign unused_addr_lsb = ^addr[1:0];

    assign req = dren | dwen;

`ifdef MEM_MISALIGN_TRAP_EN
    logic mis_q;

    assign mis_now    = access_misaligned(dwen, load_type, byte_offset, byte_en);
    assign misaligned = (state_q == MEM_DONE) && mis_q;

    always_ff @(posedge CLK) begin
        if (RST)
            mis_q <= 1'b0;
        else if (state_q == MEM_IDLE && req)
            mis_q <= mis_now;
    end
`else
    assign mis_now    = 1'b0;
    assign misaligned = 1'b0;
`endif

    // This busy cycle would be number BUS_TIMEOUT; 0 disables the abort.
    assign timeout_hit = (BUS_TIMEOUT != 0) && bus_busy && (int'(cnt_q) + 1 == BUS_TIMEOUT);

    load_extend u_load_extend (
        .rdata       (bus_rdata),
        .byte_offset (off_q),
        .load_type   (lt_q),
        .data        (ext_data)
    );

    always_ff @(posedge CLK) begin
        if (RST)
            state_q <= MEM_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MEM_IDLE:   if (req) state_d = mis_now ? MEM_DONE : MEM_ACCESS;
            MEM_ACCESS: if (!bus_busy || timeout_hit) state_d = MEM_DONE;
            MEM_DONE:   state_d = MEM_IDLE;
            default:    state_d = MEM_IDLE;
        endcase
    end

    always_comb begin
        bus_ren   = 1'b0;
        bus_wen   = 1'b0;
        mem_done  = 1'b0;
        mem_stall = 1'b0;
        case (state_q)
            MEM_IDLE:   mem_stall = req;
            MEM_ACCESS: begin
                bus_ren   = !store_q;
                bus_wen   = store_q;
                mem_stall = 1'b1;
            end
            MEM_DONE:   mem_done = 1'b1;
            default:    mem_stall = 1'b0;
        endcase
    end

    assign bus_addr    = {addr_q, 2'b00};
    assign bus_byte_en = store_q ? be_q : 4'b1111;
    assign bus_wdata   = wdata_q;
    assign bus_error   = mem_done && err_q;
    assign load_data   = load_data_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            addr_q      <= '0;
            be_q        <= '0;
            lt_q        <= LW;
            off_q       <= '0;
            wdata_q     <= '0;
            store_q     <= 1'b0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            load_data_q <= '0;
        end else begin
            case (state_q)
                MEM_IDLE: if (req) begin
                    addr_q  <= addr[31:2];
                    be_q    <= byte_en;
                    lt_q    <= load_type;
                    off_q   <= byte_offset;
                    wdata_q <= store_data << {byte_offset, 3'b000};
                    store_q <= dwen;
                    cnt_q   <= '0;
                    err_q   <= 1'b0;
                end
                MEM_ACCESS: begin
                    if (bus_busy) begin
                        if (cnt_q != '1)
                            cnt_q <= cnt_q + 1'b1;
                        if (timeout_hit) begin
                            err_q       <= 1'b1;
                            load_data_q <= '0;
                        end
                    end else if (!store_q) begin
                        load_data_q <= ext_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a per-cycle expectation model checked at every negedge.
module tb_mem_access_unit;
    import rv32i_types_pkg::*;

    localparam int TO = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        dren = 1'b0, dwen = 1'b0;
    logic [3:0]  byte_en = '0;
    load_t       load_type = LW;
    logic [1:0]  byte_offset = '0;
    logic [31:0] addr = '0, store_data = '0;
    logic [31:0] bus_addr, bus_wdata, bus_rdata = '0, load_data;
    logic        bus_ren, bus_wen, bus_busy = 1'b0;
    logic [3:0]  bus_byte_en;
    logic        mem_stall, mem_done, bus_error, misaligned;

    int tests = 0;
    int fails = 0;

    logic        chk_on = 1'b0;
    logic        e_stall, e_ren, e_wen, e_done, e_err, e_mis;
    logic [31:0] e_ld = '0, e_addr, e_wdata;
    logic [3:0]  e_be;
    logic [31:0] last_wdata = '0;
    logic [3:0]  last_be = '0;
    logic        saw_err = 1'b0, saw_mis = 1'b0;

    mem_access_unit #(.BUS_TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST), .dren(dren), .dwen(dwen), .byte_en(byte_en),
        .load_type(load_type), .byte_offset(byte_offset), .addr(addr),
        .store_data(store_data), .bus_addr(bus_addr), .bus_ren(bus_ren),
        .bus_wen(bus_wen), .bus_byte_en(bus_byte_en), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_busy(bus_busy), .load_data(load_data),
        .mem_stall(mem_stall), .mem_done(mem_done), .bus_error(bus_error),
        .misaligned(misaligned)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", nm, $time, act, exp);
        end
    endtask

    // Reference rules: shift the word down by the offset, then extend per load kind.
    function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [1:0] off, input load_t lt);
        logic [31:0] s;
        s = rd >> (8 * off);
        case (lt)
            LB:      return 32'($signed(s[7:0]));
            LH:      return 32'($signed(s[15:0]));
            LBU:     return 32'(s[7:0]);
            LHU:     return 32'(s[15:0]);
            default: return s;
        endcase
    endfunction

    function automatic logic model_mis(input bit st, input load_t lt, input logic [1:0] off, input logic [3:0] be);
`ifdef MEM_MISALIGN_TRAP_EN
        if (st) return !(be == 4'h1 || be == 4'h2 || be == 4'h4 || be == 4'h8 ||
                         be == 4'h3 || be == 4'hC || be == 4'hF);
        if (lt == LH || lt == LHU) return (off % 2) == 1;
        if (lt == LW) return off != 0;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    always @(negedge CLK) begin
        if (chk_on) begin
            chk("mem_stall", 32'(mem_stall), 32'(e_stall));
            chk("bus_ren",   32'(bus_ren),   32'(e_ren));
            chk("bus_wen",   32'(bus_wen),   32'(e_wen));
            chk("mem_done",  32'(mem_done),  32'(e_done));
            chk("bus_error", 32'(bus_error), 32'(e_err));
            chk("misaligned", 32'(misaligned), 32'(e_mis));
            chk("load_data", load_data, e_ld);
            if (e_ren || e_wen) begin
                chk("bus_addr", bus_addr, e_addr);
                chk("bus_byte_en", 32'(bus_byte_en), 32'(e_be));
            end
            if (e_wen) begin
                chk("bus_wdata", bus_wdata, e_wdata);
                last_wdata = bus_wdata;
                last_be    = bus_byte_en;
            end
            if (bus_error === 1'b1) saw_err = 1'b1;
            if (misaligned === 1'b1) saw_mis = 1'b1;
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_idle();
        e_stall = 0; e_ren = 0; e_wen = 0; e_done = 0; e_err = 0; e_mis = 0;
    endtask

    // One request; nbusy busy cycles before completion; rst_at>0 resets in that ACCESS cycle.
    task automatic do_access(input bit st, input bit both, input load_t lt, input logic [31:0] a,
                             input logic [1:0] off, input logic [3:0] be, input logic [31:0] sd,
                             input logic [31:0] rd, input int nbusy, input int rst_at);
        bit m;
        int nacc;
        bit tmo;
        dwen = st; dren = !st || both;
        addr = a; byte_offset = off; byte_en = be; load_type = lt; store_data = sd;
        set_idle(); e_stall = 1;
        m = model_mis(st, lt, off, be);
        step();
        dren = 0; dwen = 0; addr = $urandom; store_data = $urandom;
        byte_en = ~be; byte_offset = off + 2'd1; load_type = LBU;
        if (m) begin
            set_idle(); e_done = 1; e_mis = 1; dren = 1;
            step();
            dren = 0; set_idle();
            step();
            return;
        end
        tmo  = (nbusy >= TO);
        nacc = tmo ? TO : nbusy + 1;
        for (int i = 1; i <= nacc; i++) begin
            bus_busy  = (i <= nbusy);
            bus_rdata = (i <= nbusy) ? 32'($urandom) : rd;
            set_idle(); e_stall = 1; e_ren = !st; e_wen = st;
            e_addr = {a[31:2], 2'b00}; e_be = st ? be : 4'hF; e_wdata = sd << (8 * off);
            if (rst_at == i) RST = 1;
            step();
            if (rst_at == i) begin
                RST = 0; bus_busy = 0; set_idle(); e_ld = 0;
                step();
                step();
                return;
            end
        end
        bus_busy = 0;
        set_idle(); e_done = 1; dren = 1;
        if (tmo) begin
            e_err = 1; e_ld = 0;
        end else if (!st) begin
            e_ld = model_load(rd, off, lt);
        end
        step();
        dren = 0; set_idle();
        step();
    endtask

    initial begin
        set_idle(); e_ld = 0; e_addr = 0; e_wdata = 0; e_be = 0;
        step();
        chk_on = 1;
        step();
        RST = 0;
        step();

        do_access(0, 0, LW, 32'h100, 2'd0, 4'h0, 0, 32'hDEADBEEF, 0, 0);
        chk("pin_lw", load_data, 32'hDEADBEEF);
        do_access(0, 0, LB, 32'h203, 2'd3, 4'h0, 0, 32'h80FFFFFF, 0, 0);
        chk("pin_lb", load_data, 32'hFFFFFF80);
        do_access(0, 0, LBU, 32'h203, 2'd3, 4'h0, 0, 32'h80FFFFFF, 1, 0);
        chk("pin_lbu", load_data, 32'h00000080);
        do_access(1, 0, LW, 32'h302, 2'd2, 4'b1100, 32'h1234, 0, 0, 0);
        chk("pin_sh_wdata", last_wdata, 32'h12340000);
        chk("pin_sh_be", 32'(last_be), 32'hC);
        chk("pin_store_keeps_ld", load_data, 32'h00000080);
        do_access(0, 0, LH, 32'h402, 2'd2, 4'h0, 0, 32'h80010000, 2, 0);
        chk("pin_lh", load_data, 32'hFFFF8001);
        do_access(0, 0, LHU, 32'h400, 2'd0, 4'h0, 0, 32'h1234F00D, 0, 0);
        chk("pin_lhu", load_data, 32'h0000F00D);
        do_access(1, 1, LW, 32'h501, 2'd1, 4'b0010, 32'hAB, 0, 1, 0);
        chk("pin_sb_both_wdata", last_wdata, 32'h0000AB00);
        do_access(0, 0, LW, 32'h600, 2'd0, 4'h0, 0, 32'hCAFEF00D, 3, 0);
        chk("pin_lw_busy3", load_data, 32'hCAFEF00D);

        saw_err = 0;
        do_access(0, 0, LW, 32'h700, 2'd0, 4'h0, 0, 32'h55555555, 10, 0);
        chk("pin_timeout_err", 32'(saw_err), 32'h1);
        chk("pin_timeout_ld", load_data, 32'h0);

        do_access(0, 0, LW, 32'h800, 2'd0, 4'h0, 0, 32'h77777777, 1, 0);
        do_access(0, 0, LW, 32'h900, 2'd0, 4'h0, 0, 32'h12345678, 10, 2);
        chk("pin_reset_abort_ld", load_data, 32'h0);

        saw_mis = 0;
        do_access(0, 0, LW, 32'hA01, 2'd1, 4'h0, 0, 32'h11223344, 0, 0);
`ifdef MEM_MISALIGN_TRAP_EN
        chk("pin_lw_misaligned", 32'(saw_mis), 32'h1);
`else
        chk("pin_lw_off1", load_data, 32'h00112233);
`endif
        do_access(1, 0, LW, 32'hB00, 2'd1, 4'b0110, 32'hA5A5, 0, 0, 0);
        do_access(0, 0, LH, 32'hC01, 2'd1, 4'h0, 0, 32'h00ABCD00, 0, 0);

        chk_on = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
